factor_search_ctrl: RTL



---
 rtl/factor_search_pkg.sv | 25 ++
 rtl/factor_search_ctrl_cand_step.sv | 44 ++++
 rtl/factor_search_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/factor_search_pkg.sv
// Shared types and constants for the factor search engine.
//   state_t  : controller states (IDLE / SEARCH / DONE)
//   result_t : the registered result {found, f1, f2, cycles}
// The result struct is sized from FACTOR_W, so the top-level W parameter
// is expected to stay at FACTOR_W when the struct is in use.
package factor_search_pkg;

  localparam int FACTOR_W     = 4;
  localparam int FIRST_FACTOR = 2;
  localparam int MAX_FACTOR   = (1 << FACTOR_W) - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic                    found;
    logic [FACTOR_W-1:0]     f1;
    logic [FACTOR_W-1:0]     f2;
    logic [2*FACTOR_W-1:0]   cycles;
  } result_t;

endpackage

// File: rtl/factor_search_ctrl_cand_step.sv
// factor_cand_step: combinational evaluation of one candidate pair.
// Ports:
//   c1, c2    : current candidate factors (c1 <= c2)
//   tgt       : target product
//   hit       : c1*c2 equals the target
//   exhausted : no further candidate can succeed (search ends, not found)
//   next_c1/2 : the following candidate when neither hit nor exhausted
module factor_cand_step
  import factor_search_pkg::*;
#(
  parameter int W = FACTOR_W
) (
  input  logic [W-1:0]   c1,
  input  logic [W-1:0]   c2,
  input  logic [2*W-1:0] tgt,
  output logic           hit,
  output logic           exhausted,
  output logic [W-1:0]   next_c1,
  output logic [W-1:0]   next_c2
);

  // Largest representable factor (MAX_FACTOR generalised to W).
  localparam logic [W-1:0] MAX_C = {W{1'b1}};

  logic [2*W-1:0] p;
  logic           over;
  logic           advance_row;

  always_comb begin
    // Full-width product: no truncation, so the comparisons are exact.
    p           = (2*W)'(c1) * (2*W)'(c2);
    hit         = (p == tgt);
    over        = (p > tgt);
    // Leave the current row either because larger c2 can only overshoot
    // further, or because c2 has reached the top of its range.
    advance_row = over || (c2 == MAX_C);
    // Overshooting on the diagonal means every later row (c2 >= c1 > old c1)
    // overshoots too. Leaving the last row means the sweep is complete.
    exhausted   = !hit && ((over && (c2 == c1)) || (advance_row && (c1 == MAX_C)));
    next_c1     = advance_row ? c1 + W'(1) : c1;
    next_c2     = advance_row ? c1 + W'(1) : c2 + W'(1);
  end

endmodule

// File: rtl/factor_search_ctrl.sv
// factor_search_ctrl: sequential search for the first non-trivial
// factorisation tgt = f1 * f2 with 2 <= f1 <= f2 < 2^W, one pair per clock.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake; target sampled on it
//   target               : 2W-bit product to factor
//   res_valid/res_ready  : result handshake; outputs stable while waiting
//   found, f1, f2        : result (factors are 0 when found=0)
//   cycles               : number of SEARCH cycles spent on the request
module factor_search_ctrl
  import factor_search_pkg::*;
#(
  parameter int W     = FACTOR_W,
  parameter int CNT_W = 2 * W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2*W-1:0]   target,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             found,
  output logic [W-1:0]     f1,
  output logic [W-1:0]     f2,
  output logic [CNT_W-1:0] cycles
);

  state_t           state_reg, state_next;
  logic [2*W-1:0]   tgt_reg, tgt_next;
  logic [W-1:0]     c1_reg, c1_next;
  logic [W-1:0]     c2_reg, c2_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  result_t          res_reg, res_next;

  logic             hit;
  logic             exhausted;
  logic [W-1:0]     step_c1;
  logic [W-1:0]     step_c2;

  factor_cand_step #(
    .W(W)
  ) u_step (
    .c1        (c1_reg),
    .c2        (c2_reg),
    .tgt       (tgt_reg),
    .hit       (hit),
    .exhausted (exhausted),
    .next_c1   (step_c1),
    .next_c2   (step_c2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      c1_reg    <= '0;
      c2_reg    <= '0;
      cnt_reg   <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      c1_reg    <= c1_next;
      c2_reg    <= c2_next;
      cnt_reg   <= cnt_next;
      res_reg   <= res_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    c1_next    = c1_reg;
    c2_next    = c2_reg;
    cnt_next   = cnt_reg;
    res_next   = res_reg;

    unique case (state_reg)
      IDLE: begin
        if (req_valid) begin
          tgt_next   = target;
          c1_next    = W'(FIRST_FACTOR);
          c2_next    = W'(FIRST_FACTOR);
          cnt_next   = '0;
          res_next   = '0;
          state_next = SEARCH;
        end
      end

      SEARCH: begin
        // The deciding cycle is counted as well, so the recorded cycle
        // count is the incremented value.
        cnt_next = cnt_reg + CNT_W'(1);
        if (hit) begin
          res_next.found  = 1'b1;
          res_next.f1     = c1_reg;
          res_next.f2     = c2_reg;
          res_next.cycles = cnt_reg + CNT_W'(1);
          state_next      = DONE;
        end else if (exhausted) begin
          res_next.found  = 1'b0;
          res_next.f1     = '0;
          res_next.f2     = '0;
          res_next.cycles = cnt_reg + CNT_W'(1);
          state_next      = DONE;
        end else begin
          c1_next = step_c1;
          c2_next = step_c2;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags decode directly from the registered state, so they
  // take their reset values the instant rst_n is asserted.
  assign req_ready = (state_reg == IDLE);
  assign res_valid = (state_reg == DONE);
  assign found     = res_reg.found;
  assign f1        = res_reg.f1;
  assign f2        = res_reg.f2;
  assign cycles    = res_reg.cycles;

endmodule
